// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode control stage: holds the PC, fetches one instruction per transaction over a
// request/valid handshake and decodes RV32I R-type instructions for the register-file/ALU datapath.
module fetch_decode_ctrl #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned COUNT_W        = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_rvalid,
    input  logic [31:0]        imem_rdata,
    output logic [4:0]         read_reg_num1,
    output logic [4:0]         read_reg_num2,
    output logic [4:0]         write_reg,
    output logic [3:0]         alu_control,
    output logic               regwrite,
    output logic               illegal_instr,
    output logic               fetch_error,
    output logic [31:0]        pc,
    output logic [COUNT_W-1:0] instr_count
);

    localparam int unsigned     TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_EXEC = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    // Returns {legal, alu_control}; only the ten RV32I R-type ALU operations are legal.
    function automatic logic [4:0] decode_r_type(input logic [31:0] instr);
        logic [4:0] res;
        res = {1'b0, 4'b0000};
        if (instr[6:0] == 7'b0110011) begin
            case ({instr[31:25], instr[14:12]})
                10'b0000000_000: res = {1'b1, 4'b0010};
                10'b0100000_000: res = {1'b1, 4'b0110};
                10'b0000000_001: res = {1'b1, 4'b1000};
                10'b0000000_010: res = {1'b1, 4'b0111};
                10'b0000000_011: res = {1'b1, 4'b1011};
                10'b0000000_100: res = {1'b1, 4'b0100};
                10'b0000000_101: res = {1'b1, 4'b1001};
                10'b0100000_101: res = {1'b1, 4'b1010};
                10'b0000000_110: res = {1'b1, 4'b0001};
                10'b0000000_111: res = {1'b1, 4'b0000};
                default:         res = {1'b0, 4'b0000};
            endcase
        end else begin
            res = {1'b0, 4'b0000};
        end
        return res;
    endfunction

    state_t             state_r;
    logic [31:0]        pc_r;
    logic [COUNT_W-1:0] count_r;
    logic [TO_W-1:0]    to_cnt_r;
    logic               imem_req_r;
    logic [4:0]         rs1_r;
    logic [4:0]         rs2_r;
    logic [4:0]         rd_r;
    logic [3:0]         alu_r;
    logic               regwrite_r;
    logic               illegal_r;
    logic               fetch_error_r;

    logic [4:0]         dec_s;
    logic               dec_legal_s;
    logic [3:0]         dec_alu_s;
    logic [TO_W-1:0]    to_next_s;

    // Decode of the word currently on the fetch bus and next timeout count.
    always_comb begin
        dec_s       = decode_r_type(imem_rdata);
        dec_legal_s = dec_s[4];
        dec_alu_s   = dec_s[3:0];
        to_next_s   = to_cnt_r + TO_W'(1);
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            count_r       <= '0;
            to_cnt_r      <= '0;
            imem_req_r    <= 1'b0;
            rs1_r         <= 5'd0;
            rs2_r         <= 5'd0;
            rd_r          <= 5'd0;
            alu_r         <= 4'd0;
            regwrite_r    <= 1'b0;
            illegal_r     <= 1'b0;
            fetch_error_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (run) begin
                        state_r    <= ST_REQ;
                        imem_req_r <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // A response in the same cycle as the final timeout count still completes.
                    if (imem_rvalid) begin
                        state_r    <= ST_EXEC;
                        imem_req_r <= 1'b0;
                        rs1_r      <= imem_rdata[19:15];
                        rs2_r      <= imem_rdata[24:20];
                        rd_r       <= imem_rdata[11:7];
                        if (dec_legal_s) begin
                            alu_r <= dec_alu_s;
                        end
                        regwrite_r <= dec_legal_s && (imem_rdata[11:7] != 5'd0);
                        illegal_r  <= ~dec_legal_s;
                    end else if (to_next_s == TO_LIMIT) begin
                        state_r       <= ST_HALT;
                        imem_req_r    <= 1'b0;
                        fetch_error_r <= 1'b1;
                        to_cnt_r      <= to_next_s;
                    end else begin
                        to_cnt_r <= to_next_s;
                    end
                end
                ST_EXEC: begin
                    regwrite_r <= 1'b0;
                    illegal_r  <= 1'b0;
                    pc_r       <= pc_r + 32'd4;
                    count_r    <= count_r + COUNT_W'(1);
                    to_cnt_r   <= '0;
                    if (run) begin
                        state_r    <= ST_REQ;
                        imem_req_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_HALT: begin
                    imem_req_r <= 1'b0;
                    regwrite_r <= 1'b0;
                    illegal_r  <= 1'b0;
                end
                default: begin
                    state_r    <= ST_HALT;
                    imem_req_r <= 1'b0;
                    regwrite_r <= 1'b0;
                    illegal_r  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req      = imem_req_r;
    assign imem_addr     = pc_r;
    assign pc            = pc_r;
    assign instr_count   = count_r;
    assign read_reg_num1 = rs1_r;
    assign read_reg_num2 = rs2_r;
    assign write_reg     = rd_r;
    assign alu_control   = alu_r;
    assign regwrite      = regwrite_r;
    assign illegal_instr = illegal_r;
    assign fetch_error   = fetch_error_r;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Randomized scoreboard bench for fetch_decode_ctrl: a memory driver pushes predicted retirements,
// a negedge monitor pops and compares them when the stage retires an instruction.
module tb_fetch_decode_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 15;

    logic        clock;
    logic        reset;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [4:0]  read_reg_num1;
    logic [4:0]  read_reg_num2;
    logic [4:0]  write_reg;
    logic [3:0]  alu_control;
    logic        regwrite;
    logic        illegal_instr;
    logic        fetch_error;
    logic [31:0] pc;
    logic [31:0] instr_count;

    fetch_decode_ctrl #(
        .RESET_PC      (RESET_PC),
        .TIMEOUT_CYCLES(TIMEOUT),
        .COUNT_W       (32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .run          (run),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .read_reg_num1(read_reg_num1),
        .read_reg_num2(read_reg_num2),
        .write_reg    (write_reg),
        .alu_control  (alu_control),
        .regwrite     (regwrite),
        .illegal_instr(illegal_instr),
        .fetch_error  (fetch_error),
        .pc           (pc),
        .instr_count  (instr_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [31:0] addr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic        rw;
        logic        ill;
        logic [31:0] pc_after;
        logic [31:0] cnt_after;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t post_e;
    logic exec_next;
    logic post_pending;
    logic [31:0] hs_addr;

    int n_checks;
    int n_fail;

    // Reference model state, expressed directly in architectural terms.
    logic [31:0] model_pc;
    logic [31:0] model_count;
    logic [3:0]  model_alu;

    // {funct7, funct3, alu_control} for every legal R-type operation.
    logic [13:0] op_tab [10] = '{
        14'b0000000_000_0010, 14'b0100000_000_0110, 14'b0000000_001_1000,
        14'b0000000_010_0111, 14'b0000000_011_1011, 14'b0000000_100_0100,
        14'b0000000_101_1001, 14'b0100000_101_1010, 14'b0000000_110_0001,
        14'b0000000_111_0000
    };

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        model_pc    = RESET_PC;
        model_count = 32'd0;
        model_alu   = 4'd0;
        exp_q.delete();
    endtask

    // Predicts the retirement of one instruction and advances the architectural model.
    function automatic exp_t predict(input logic [31:0] instr);
        exp_t e;
        logic legal;
        logic [3:0] alu;
        legal = 1'b0;
        alu   = model_alu;
        if (instr[6:0] == 7'h33) begin
            for (int i = 0; i < 10; i++) begin
                if (op_tab[i][13:4] == {instr[31:25], instr[14:12]}) begin
                    legal = 1'b1;
                    alu   = op_tab[i][3:0];
                end
            end
        end
        e.addr      = model_pc;
        e.rs1       = instr[19:15];
        e.rs2       = instr[24:20];
        e.rd        = instr[11:7];
        e.alu       = alu;
        e.rw        = legal && (instr[11:7] != 5'd0);
        e.ill       = !legal;
        model_pc    = model_pc + 32'd4;
        model_count = model_count + 32'd1;
        model_alu   = alu;
        e.pc_after  = model_pc;
        e.cnt_after = model_count;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        int k;
        int idx;
        logic [31:0] w;
        k   = $urandom_range(0, 9);
        idx = $urandom_range(0, 9);
        w   = $urandom;
        if (k < 6) begin
            w = {op_tab[idx][13:7], w[24:15], op_tab[idx][6:4], w[11:7], 7'h33};
        end else if (k == 6) begin
            w = {op_tab[idx][13:7], w[24:15], op_tab[idx][6:4], 5'd0, 7'h33};
        end else if (k < 9) begin
            w = {w[31:7], 7'h33};
        end
        return w;
    endfunction

    // Memory responder: waits for a request, answers after lat cycles, optionally
    // pokes a stray rvalid while not requesting, and optionally parks the stage in IDLE.
    task automatic do_fetch(input logic [31:0] instr, input int lat, input bit junk, input bit pause);
        int g;
        exp_t e;
        g = 0;
        while (!imem_req && g < 50) begin
            tick();
            g++;
        end
        if (!imem_req) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_wait: imem_req never rose, got 0 expected 1");
            return;
        end
        repeat (lat) tick();
        e = predict(instr);
        exp_q.push_back(e);
        imem_rvalid = 1'b1;
        imem_rdata  = instr;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pause) run = 1'b0;
        if (junk) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'h0020_81B3;
            tick();
            imem_rvalid = 1'b0;
        end
        if (pause) begin
            repeat (2) tick();
            @(negedge clock);
            chk("idle_req", imem_req, 1'b0);
            chk("idle_pc", pc, model_pc);
            tick();
            run = 1'b1;
        end
    endtask

    // Monitor: retirement is the cycle after an accepted handshake.
    initial begin
        exec_next    = 1'b0;
        post_pending = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                exec_next    = 1'b0;
                post_pending = 1'b0;
            end else begin
                if (post_pending) begin
                    chk("pc_after", pc, post_e.pc_after);
                    chk("count_after", instr_count, post_e.cnt_after);
                    post_pending = 1'b0;
                end
                if (exec_next) begin
                    exec_next = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL exec_unexpected: retirement with empty scoreboard, got 1 expected 0");
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("fetch_addr", hs_addr, mon_e.addr);
                        chk("rs1", read_reg_num1, mon_e.rs1);
                        chk("rs2", read_reg_num2, mon_e.rs2);
                        chk("rd", write_reg, mon_e.rd);
                        chk("alu_control", alu_control, mon_e.alu);
                        chk("regwrite", regwrite, mon_e.rw);
                        chk("illegal_instr", illegal_instr, mon_e.ill);
                        post_e       = mon_e;
                        post_pending = 1'b1;
                    end
                end else begin
                    chk("quiet_regwrite", regwrite, 1'b0);
                    chk("quiet_illegal", illegal_instr, 1'b0);
                end
                if (imem_req && imem_rvalid) begin
                    exec_next = 1'b1;
                    hs_addr   = imem_addr;
                end
            end
        end
    end

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || exec_next || post_pending) && g < 20) begin
            tick();
            g++;
        end
        if (g >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d retirements outstanding, expected 0", exp_q.size());
        end
    endtask

    initial begin
        int n;
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        run         = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("rst_req", imem_req, 1'b0);
            chk("rst_pc", pc, RESET_PC);
            chk("rst_regwrite", regwrite, 1'b0);
            chk("rst_fetch_error", fetch_error, 1'b0);
            chk("rst_count", instr_count, 32'd0);
        end
        tick();
        run = 1'b1;

        do_fetch(32'h0020_81B3, 2, 1'b0, 1'b0);
        do_fetch(32'h4073_02B3, 0, 1'b0, 1'b0);
        do_fetch(32'h0020_8033, 1, 1'b1, 1'b0);
        do_fetch(32'h0010_0093, 0, 1'b0, 1'b1);
        do_fetch(32'h4020_81B3, 1, 1'b0, 1'b0);
        do_fetch(32'h4020_C1B3, 0, 1'b0, 1'b0);
        for (int i = 0; i < 80; i++) begin
            do_fetch(rand_instr(), $urandom_range(0, 3),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
        end
        drain();
        chk("count_total", instr_count, 32'd86);

        // Fetch timeout: no response ever arrives.
        reset = 1'b1;
        run   = 1'b0;
        repeat (2) tick();
        model_reset();
        reset = 1'b0;
        run   = 1'b1;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        n = 0;
        while (imem_req && n < 40) begin
            n++;
            @(negedge clock);
        end
        chk("timeout_req_cycles", n, TIMEOUT);
        chk("timeout_fetch_error", fetch_error, 1'b1);
        chk("timeout_req_low", imem_req, 1'b0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0020_81B3;
        repeat (3) tick();
        imem_rvalid = 1'b0;
        repeat (2) tick();
        @(negedge clock);
        chk("halt_req", imem_req, 1'b0);
        chk("halt_sticky", fetch_error, 1'b1);
        chk("halt_pc", pc, RESET_PC);
        chk("halt_count", instr_count, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("clr_fetch_error", fetch_error, 1'b0);
        chk("clr_pc", pc, RESET_PC);

        // Reset while a fetch is outstanding; response lands during reset.
        tick();
        n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        chk("mid_req_up", imem_req, 1'b1);
        tick();
        reset       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0020_81B3;
        repeat (2) tick();
        imem_rvalid = 1'b0;
        run         = 1'b0;
        reset       = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("abort_regwrite", regwrite, 1'b0);
            chk("abort_pc", pc, RESET_PC);
            chk("abort_count", instr_count, 32'd0);
            chk("abort_req", imem_req, 1'b0);
        end

        // Stage still works after the aborted fetch.
        tick();
        run = 1'b1;
        do_fetch(32'h0020_81B3, 1, 1'b0, 1'b0);
        do_fetch(rand_instr(), 2, 1'b0, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
